// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: instruction/flag inputs and datapath control lines of the multicycle controller.
// master: the controller side; slave: the datapath/memory side.
interface mc_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memReady;
    logic       memRead;
    logic       memWrite;
    logic       iorD;
    logic       irWrite;
    logic       pcEn;
    logic [1:0] pcSrc;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluControl;
    logic       regDst;
    logic       memToReg;
    logic       regWrite;
    logic       illegalOp;
    logic       memErr;
    logic [3:0] state;

    modport master (
        input  op, funct, zero, memReady,
        output memRead, memWrite, iorD, irWrite, pcEn, pcSrc, aluSrcA, aluSrcB,
               aluControl, regDst, memToReg, regWrite, illegalOp, memErr, state
    );

    modport slave (
        output op, funct, zero, memReady,
        input  memRead, memWrite, iorD, irWrite, pcEn, pcSrc, aluSrcA, aluSrcB,
               aluControl, regDst, memToReg, regWrite, illegalOp, memErr, state
    );
endinterface

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS control FSM (fetch/decode/execute over a shared ALU and memory).
// Memory states wait on memReady with a WAIT_MAX-cycle timeout that aborts to FETCH.
// Optional build macro MC_CTRL_BNE_EN adds bne (op 000101) via the BRANCH state.
module mc_ctrl #(
    parameter int unsigned WAIT_MAX = 16
) (
    input  logic      clk,
    input  logic      rst,
    mc_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExecute = 4'd6,
        StAluWb   = 4'd7,
        StBranch  = 4'd8,
        StAddiEx  = 4'd9,
        StAddiWb  = 4'd10,
        StJump    = 4'd11
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;
`ifdef MC_CTRL_BNE_EN
    localparam logic [5:0] OpBne   = 6'b000101;
`endif

    localparam logic [7:0] WaitLast = 8'(WAIT_MAX - 1);

    state_e     stateQ, stateD;
    logic [7:0] waitCntQ, waitCntD;
    logic       inMem;
    logic       timeout;
    logic       rtypeOk;
    logic       illegal;
`ifdef MC_CTRL_BNE_EN
    logic       isBneQ, isBneD;
`endif

    // Timeout condition: a memory state still stalled on its last allowed cycle.
    always_comb begin
        inMem   = (stateQ == StFetch) || (stateQ == StMemRd) || (stateQ == StMemWr);
        timeout = inMem && !bus.memReady && (waitCntQ == WaitLast);
        rtypeOk = (bus.funct == 6'b100000) || (bus.funct == 6'b100010) ||
                  (bus.funct == 6'b100100) || (bus.funct == 6'b100101) ||
                  (bus.funct == 6'b101010);
    end

    // Next-state, wait counter and bne flag.
    always_comb begin
        stateD  = stateQ;
        illegal = 1'b0;
`ifdef MC_CTRL_BNE_EN
        isBneD  = isBneQ;
`endif
        case (stateQ)
            StFetch:   if (bus.memReady) stateD = StDecode;
            StDecode: begin
`ifdef MC_CTRL_BNE_EN
                isBneD = (bus.op == OpBne);
`endif
                case (bus.op)
                    OpRtype: begin
                        if (rtypeOk) begin
                            stateD = StExecute;
                        end else begin
                            stateD  = StFetch;
                            illegal = 1'b1;
                        end
                    end
                    OpLw, OpSw: stateD = StMemAdr;
                    OpBeq:      stateD = StBranch;
`ifdef MC_CTRL_BNE_EN
                    OpBne:      stateD = StBranch;
`endif
                    OpAddi:     stateD = StAddiEx;
                    OpJ:        stateD = StJump;
                    default: begin
                        stateD  = StFetch;
                        illegal = 1'b1;
                    end
                endcase
            end
            StMemAdr:  stateD = (bus.op == OpSw) ? StMemWr : StMemRd;
            StMemRd:   if (bus.memReady) stateD = StMemWb;
            StMemWr:   if (bus.memReady) stateD = StFetch;
            StExecute: stateD = StAluWb;
            StAddiEx:  stateD = StAddiWb;
            default:   stateD = StFetch;
        endcase
        if (timeout) stateD = StFetch;

        // A FETCH timeout stays in FETCH, so clear explicitly to give the retry a full budget.
        if ((stateD != stateQ) || timeout) begin
            waitCntD = 8'd0;
        end else if (inMem && !bus.memReady) begin
            waitCntD = waitCntQ + 8'd1;
        end else begin
            waitCntD = waitCntQ;
        end
    end

    // FSM state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ   <= StFetch;
            waitCntQ <= 8'd0;
`ifdef MC_CTRL_BNE_EN
            isBneQ   <= 1'b0;
`endif
        end else begin
            stateQ   <= stateD;
            waitCntQ <= waitCntD;
`ifdef MC_CTRL_BNE_EN
            isBneQ   <= isBneD;
`endif
        end
    end

    // Moore decode of state, plus the memReady/zero/timeout-gated strobes.
    always_comb begin
        bus.memRead    = 1'b0;
        bus.memWrite   = 1'b0;
        bus.iorD       = 1'b0;
        bus.irWrite    = 1'b0;
        bus.pcEn       = 1'b0;
        bus.pcSrc      = 2'b00;
        bus.aluSrcA    = 1'b0;
        bus.aluSrcB    = 2'b00;
        bus.aluControl = 3'b000;
        bus.regDst     = 1'b0;
        bus.memToReg   = 1'b0;
        bus.regWrite   = 1'b0;
        bus.illegalOp  = 1'b0;
        bus.memErr     = timeout;
        bus.state      = stateQ;
        case (stateQ)
            StFetch: begin
                bus.memRead    = 1'b1;
                bus.aluSrcB    = 2'b01;
                bus.aluControl = 3'b010;
                bus.irWrite    = bus.memReady;
                bus.pcEn       = bus.memReady;
            end
            StDecode: begin
                bus.aluSrcB    = 2'b11;
                bus.aluControl = 3'b010;
                bus.illegalOp  = illegal;
            end
            StMemAdr, StAddiEx: begin
                bus.aluSrcA    = 1'b1;
                bus.aluSrcB    = 2'b10;
                bus.aluControl = 3'b010;
            end
            StMemRd: begin
                bus.memRead = 1'b1;
                bus.iorD    = 1'b1;
            end
            StMemWb: begin
                bus.regWrite = 1'b1;
                bus.memToReg = 1'b1;
            end
            StMemWr: begin
                bus.memWrite = !timeout;
                bus.iorD     = 1'b1;
            end
            StExecute: begin
                bus.aluSrcA = 1'b1;
                case (bus.funct)
                    6'b100010: bus.aluControl = 3'b110;
                    6'b100100: bus.aluControl = 3'b000;
                    6'b100101: bus.aluControl = 3'b001;
                    6'b101010: bus.aluControl = 3'b111;
                    default:   bus.aluControl = 3'b010;
                endcase
            end
            StAluWb: begin
                bus.regWrite = 1'b1;
                bus.regDst   = 1'b1;
            end
            StBranch: begin
                bus.aluSrcA    = 1'b1;
                bus.aluControl = 3'b110;
                bus.pcSrc      = 2'b01;
`ifdef MC_CTRL_BNE_EN
                bus.pcEn       = isBneQ ? !bus.zero : bus.zero;
`else
                bus.pcEn       = bus.zero;
`endif
            end
            StAddiWb: bus.regWrite = 1'b1;
            StJump: begin
                bus.pcSrc = 2'b10;
                bus.pcEn  = 1'b1;
            end
            default: ;
        endcase
        // Reset holds every strobe low; selects keep their FETCH values.
        if (!rst) begin
            bus.memRead   = 1'b0;
            bus.memWrite  = 1'b0;
            bus.irWrite   = 1'b0;
            bus.pcEn      = 1'b0;
            bus.regWrite  = 1'b0;
            bus.illegalOp = 1'b0;
            bus.memErr    = 1'b0;
        end
    end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed and randomized check of mc_ctrl against an instruction-level model.
// The model holds each instruction as a list of micro-steps and walks it cycle by cycle.
module tb_mc_ctrl;
    localparam int unsigned WaitMax = 4;

    localparam int SFetch = 0, SDecode = 1, SMemAdr = 2, SMemRd = 3, SMemWb = 4, SMemWr = 5;
    localparam int SExec = 6, SAluWb = 7, SBranch = 8, SAddiEx = 9, SAddiWb = 10, SJump = 11;

    // {memRead,memWrite,iorD,irWrite,pcEn,pcSrc,aluSrcA,aluSrcB,aluControl,
    //  regDst,memToReg,regWrite,illegalOp,memErr}
    localparam logic [17:0] ResetVec = {5'b00000, 2'b00, 1'b0, 2'b01, 3'b010, 5'b00000};

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mc_ctrl_if bus();

    mc_ctrl #(.WAIT_MAX(WaitMax)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cmpCnt = 0;
    int errCnt = 0;

    int         steps[$];
    int         waits = 0;
    bit         curIllegal;
    bit         curBne;
    logic [2:0] curAlu;

    logic [5:0] rFunct [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] rAlu   [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    logic [5:0] badOps [4] = '{6'b111111, 6'b000011, 6'b001101, 6'b100000};
    logic [5:0] badFn  [4] = '{6'b000000, 6'b100001, 6'b001000, 6'b100110};

    task automatic check(input string tag, input logic [17:0] got, input logic [17:0] want);
        cmpCnt++;
        assert (got === want) else begin
            errCnt++;
            $error("FAIL %s at %0t: got %b want %b", tag, $time, got, want);
        end
    endtask

    // Kinds: 0-4 R-type, 5 lw, 6 sw, 7 beq, 8 addi, 9 j, 10 bne, 11 bad op, 12 bad funct.
    task automatic loadInstr(input int kind);
        curIllegal = 1'b0;
        curBne     = 1'b0;
        curAlu     = 3'b010;
        waits      = 0;
        bus.funct  = 6'($urandom);
        if (kind <= 4) begin
            bus.op    = 6'b000000;
            bus.funct = rFunct[kind];
            curAlu    = rAlu[kind];
            steps     = '{SFetch, SDecode, SExec, SAluWb};
        end else if (kind == 5) begin
            bus.op = 6'b100011;
            steps  = '{SFetch, SDecode, SMemAdr, SMemRd, SMemWb};
        end else if (kind == 6) begin
            bus.op = 6'b101011;
            steps  = '{SFetch, SDecode, SMemAdr, SMemWr};
        end else if (kind == 7) begin
            bus.op = 6'b000100;
            steps  = '{SFetch, SDecode, SBranch};
        end else if (kind == 8) begin
            bus.op = 6'b001000;
            steps  = '{SFetch, SDecode, SAddiEx, SAddiWb};
        end else if (kind == 9) begin
            bus.op = 6'b000010;
            steps  = '{SFetch, SDecode, SJump};
        end else if (kind == 10) begin
            bus.op = 6'b000101;
`ifdef MC_CTRL_BNE_EN
            curBne = 1'b1;
            steps  = '{SFetch, SDecode, SBranch};
`else
            curIllegal = 1'b1;
            steps      = '{SFetch, SDecode};
`endif
        end else if (kind == 11) begin
            bus.op     = badOps[$urandom_range(0, 3)];
            curIllegal = 1'b1;
            steps      = '{SFetch, SDecode};
        end else begin
            bus.op     = 6'b000000;
            bus.funct  = badFn[$urandom_range(0, 3)];
            curIllegal = 1'b1;
            steps      = '{SFetch, SDecode};
        end
    endtask

    function automatic logic [17:0] expVec(input int step, input logic rdy, input logic z,
                                           input bit tmo);
        logic       mRd, mWr, iord, irW, pcE, srcA, rDst, m2r, rW, ill;
        logic [1:0] pcS, srcB;
        logic [2:0] ctl;
        {mRd, mWr, iord, irW, pcE, srcA, rDst, m2r, rW, ill} = '0;
        pcS  = 2'b00;
        srcB = 2'b00;
        ctl  = 3'b000;
        case (step)
            SFetch:  begin mRd = 1; srcB = 2'b01; ctl = 3'b010; irW = rdy; pcE = rdy; end
            SDecode: begin srcB = 2'b11; ctl = 3'b010; ill = curIllegal; end
            SMemAdr: begin srcA = 1; srcB = 2'b10; ctl = 3'b010; end
            SMemRd:  begin mRd = 1; iord = 1; end
            SMemWb:  begin rW = 1; m2r = 1; end
            SMemWr:  begin mWr = !tmo; iord = 1; end
            SExec:   begin srcA = 1; ctl = curAlu; end
            SAluWb:  begin rW = 1; rDst = 1; end
            SBranch: begin srcA = 1; ctl = 3'b110; pcS = 2'b01; pcE = curBne ? !z : z; end
            SAddiEx: begin srcA = 1; srcB = 2'b10; ctl = 3'b010; end
            SAddiWb: rW = 1;
            SJump:   begin pcS = 2'b10; pcE = 1; end
            default: ;
        endcase
        return {mRd, mWr, iord, irW, pcE, pcS, srcA, srcB, ctl, rDst, m2r, rW, ill, tmo};
    endfunction

    function automatic logic [17:0] dutVec();
        return {bus.memRead, bus.memWrite, bus.iorD, bus.irWrite, bus.pcEn, bus.pcSrc,
                bus.aluSrcA, bus.aluSrcB, bus.aluControl, bus.regDst, bus.memToReg,
                bus.regWrite, bus.illegalOp, bus.memErr};
    endfunction

    // One clock: drive at edge+1, check at edge+4, advance the model, wait for next edge+1.
    task automatic cycle(input logic rdy, input logic z);
        int  step;
        bit  isMem;
        bit  tmo;
        if (steps.size() == 0) loadInstr(int'($urandom_range(0, 12)));
        step         = steps[0];
        bus.memReady = rdy;
        bus.zero     = z;
        #3;
        isMem = (step == SFetch) || (step == SMemRd) || (step == SMemWr);
        tmo   = isMem && !rdy && (waits == int'(WaitMax) - 1);
        check($sformatf("state(step %0d)", step), 18'(bus.state), 18'(step));
        check($sformatf("outputs(step %0d)", step), dutVec(), expVec(step, rdy, z, tmo));
        if (isMem && !rdy) begin
            if (tmo) begin
                waits = 0;
                if (step != SFetch) steps.delete();
            end else begin
                waits++;
            end
        end else begin
            void'(steps.pop_front());
            waits = 0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.op       = 6'b0;
        bus.funct    = 6'b0;
        bus.zero     = 1'b0;
        bus.memReady = 1'b1;

        // Reset held 3 cycles with memReady high: strobes must stay low.
        repeat (3) begin
            @(posedge clk);
            #1;
            check("reset state", 18'(bus.state), 18'd0);
            check("reset outputs", dutVec(), ResetVec);
        end
        rst = 1'b1;

        // R-type add, zero-wait.
        loadInstr(0);
        repeat (4) cycle(1'b1, 1'b0);

        // lw with two wait cycles in MEMRD: 7 cycles total.
        loadInstr(5);
        cycle(1, 0); cycle(1, 0); cycle(1, 0); cycle(0, 0); cycle(0, 0); cycle(1, 0); cycle(1, 0);

        // beq taken, then not taken.
        loadInstr(7);
        cycle(1, 1); cycle(1, 1); cycle(1, 1);
        loadInstr(7);
        cycle(1, 0); cycle(1, 0); cycle(1, 0);

        // sw with memReady stuck low: timeout on the 4th MEMWR cycle.
        loadInstr(6);
        cycle(1, 0); cycle(1, 0); cycle(1, 0);
        repeat (4) cycle(1'b0, 1'b0);

        // Illegal op, bne with zero=0, illegal R-type funct.
        loadInstr(11);
        bus.op = 6'b111111;
        cycle(1, 0); cycle(1, 0);
        loadInstr(10);
        while (steps.size() != 0) cycle(1'b1, 1'b0);
        loadInstr(12);
        cycle(1, 0); cycle(1, 0);

        // Fetch timeout and retry, then the jump completes.
        loadInstr(9);
        repeat (4) cycle(1'b0, 1'b0);
        cycle(1, 0); cycle(1, 0); cycle(1, 0);

        // Reset in MEMRD abandons the lw.
        loadInstr(5);
        cycle(1, 0); cycle(1, 0); cycle(1, 0);
        bus.memReady = 1'b1;
        rst          = 1'b0;
        #1;
        check("midreset state", 18'(bus.state), 18'd0);
        check("midreset outputs", dutVec(), ResetVec);
        @(posedge clk);
        #1;
        rst = 1'b1;
        steps.delete();
        waits = 0;

        // Randomized instruction stream with random stalls and zero flag.
        repeat (2000) cycle(logic'($urandom_range(0, 9) < 6), logic'($urandom_range(0, 1)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
        $finish;
    end
endmodule
